// File: rtl/e_mdu_param_if.sv
// e_mdu_param_if: E-stage request/response bundle for the multiply/divide unit.
//   op, cancel, rs_val, rt_val : request from the pipeline (master -> slave)
//   busy                       : stall request to the hazard controller
//   out                        : MFHI/MFLO read data toward the E->M register
//   hi, lo                     : committed HI/LO, debug visibility
interface e_mdu_param_if #(
  parameter int WIDTH = 32
);
  logic [3:0]       op;
  logic             cancel;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             busy;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output op, cancel, rs_val, rt_val,
    input  busy, out, hi, lo
  );

  modport slave (
    input  op, cancel, rs_val, rt_val,
    output busy, out, hi, lo
  );
endinterface

// File: rtl/e_mdu_param.sv
// e_mdu_param: parametrised multiply/divide unit with HI/LO for the E stage.
//   The result is computed at issue and held in a pending register; a
//   down-counter models the unit latency and the pending value commits to
//   HI/LO on the terminal count (cnt 1 -> 0).
// Ports:
//   clk    : clock, all state on the rising edge
//   reset  : synchronous, active-high, clears all state
//   bus    : e_mdu_param_if slave (op, cancel, rs_val, rt_val -> busy, out, hi, lo)
//
// cnt | meaning
// ----+---------------------------------------------
//  0  | idle: accepts issue and MTHI/MTLO
//  n  | n cycles left; pending result commits at 1->0
module e_mdu_param #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input logic         clk,
  input logic         reset,
  e_mdu_param_if.slave bus
);
  localparam int CNT_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;

  if (MUL_CYCLES < 1 || DIV_CYCLES < 1) begin : g_bad_latency
    $error("e_mdu_param: MUL_CYCLES and DIV_CYCLES must be >= 1");
  end

  logic [WIDTH-1:0] hi_q, lo_q;
  logic [WIDTH-1:0] pend_hi, pend_lo;
  logic             pend_we;
  logic [CW-1:0]    cnt;

  logic is_mul, is_div, is_signed, idle, issue;
  logic [2*WIDTH-1:0] a_ext, b_ext, prod, acc, mul_res;
  logic             a_neg, b_neg, div_ok;
  logic [WIDTH-1:0] a_mag, b_mag, q_mag, r_mag, quo, rem;

  always_comb begin
    is_mul    = bus.op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
    is_div    = bus.op inside {OP_DIV, OP_DIVU};
    is_signed = bus.op inside {OP_MULT, OP_MADD, OP_MSUB, OP_DIV};
    idle      = (cnt == '0);
    issue     = (is_mul | is_div) & ~bus.cancel & idle;
  end

  // One 2W x 2W multiplier serves both signednesses: the low 2W bits of the
  // product of the extended operands equal the signed or unsigned product.
  always_comb begin
    a_ext = {{WIDTH{is_signed & bus.rs_val[WIDTH-1]}}, bus.rs_val};
    b_ext = {{WIDTH{is_signed & bus.rt_val[WIDTH-1]}}, bus.rt_val};
    prod  = a_ext * b_ext;
    acc   = {hi_q, lo_q};
    unique case (bus.op)
      OP_MADD, OP_MADDU: mul_res = acc + prod;
      OP_MSUB, OP_MSUBU: mul_res = acc - prod;
      default:           mul_res = prod;
    endcase
  end

  // Signed divide on magnitudes. The most-negative / -1 case falls out
  // naturally: the magnitude quotient 2^(W-1) reads back as most-negative.
  always_comb begin
    a_neg  = is_signed & bus.rs_val[WIDTH-1];
    b_neg  = is_signed & bus.rt_val[WIDTH-1];
    a_mag  = a_neg ? -bus.rs_val : bus.rs_val;
    b_mag  = b_neg ? -bus.rt_val : bus.rt_val;
    div_ok = (bus.rt_val != '0);
    q_mag  = div_ok ? a_mag / b_mag : '0;
    r_mag  = div_ok ? a_mag % b_mag : '0;
    quo    = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem    = a_neg ? -r_mag : r_mag;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q    <= '0;
      lo_q    <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_we <= 1'b0;
      cnt     <= '0;
    end else begin
      if (issue) begin
        cnt     <= is_div ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
        pend_we <= is_mul | div_ok;
        if (is_div) begin
          pend_hi <= rem;
          pend_lo <= quo;
        end else begin
          {pend_hi, pend_lo} <= mul_res;
        end
      end else if (!idle) begin
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1) && pend_we) begin
          hi_q <= pend_hi;
          lo_q <= pend_lo;
        end
      end
      if (idle && !bus.cancel && bus.op == OP_MTHI) hi_q <= bus.rs_val;
      if (idle && !bus.cancel && bus.op == OP_MTLO) lo_q <= bus.rs_val;
    end
  end

  assign bus.busy = ~idle | issue;
  assign bus.out  = (bus.op == OP_MFHI) ? hi_q :
                    (bus.op == OP_MFLO) ? lo_q : '0;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

  // The pipeline stalls on busy, so a state-changing op never arrives mid-flight.
  a_no_op_in_flight: assert property (@(posedge clk) disable iff (reset)
    !(!idle && !bus.cancel &&
      (is_mul || is_div || bus.op == OP_MTHI || bus.op == OP_MTLO)));
endmodule

// File: tb/tb_e_mdu_param.sv
// tb_e_mdu_param: self-checking bench for e_mdu_param (32-bit default and a
// 16-bit / MUL_CYCLES=1 / DIV_CYCLES=3 instance). Directed table plus random
// ops checked against an arithmetic reference model.
module tb_e_mdu_param;
  localparam logic [3:0] NONE = 4'd0, MULT = 4'd1, MULTU = 4'd2, DIV = 4'd3, DIVU = 4'd4;
  localparam logic [3:0] MFHI = 4'd5, MFLO = 4'd6, MTHI = 4'd7, MTLO = 4'd8;
  localparam logic [3:0] MADD = 4'd9, MADDU = 4'd10, MSUB = 4'd11, MSUBU = 4'd12;

  typedef longint unsigned u64_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst32, rst16;
  e_mdu_param_if #(.WIDTH(32)) m32 ();
  e_mdu_param_if #(.WIDTH(16)) m16 ();

  e_mdu_param u32 (.clk(clk), .reset(rst32), .bus(m32.slave));
  e_mdu_param #(.WIDTH(16), .MUL_CYCLES(1), .DIV_CYCLES(3))
    u16 (.clk(clk), .reset(rst16), .bus(m16.slave));

  int errors = 0;
  int checks = 0;
  logic [31:0] mh [2];
  logic [31:0] ml [2];

  typedef struct {
    bit          sel;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic        c, cl;
    logic [31:0] eout, ehi, elo;
    int          cyc;
  } vec_t;
  vec_t tbl [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic longint sext(input u64_t v, input int w);
    return longint'(v << (64 - w)) >>> (64 - w);
  endfunction

  // Reference model: returns {write_enable, new_hi, new_lo}.
  function automatic logic [64:0] model(input int w, input logic [3:0] o,
                                        input logic [31:0] a, b, h, l);
    u64_t m1, m2, ua, ub, acc, r;
    longint sa, sb;
    logic we;
    m1  = (u64_t'(1) << w) - 1;
    m2  = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : (u64_t'(1) << (2 * w)) - 1;
    ua  = u64_t'(a) & m1;
    ub  = u64_t'(b) & m1;
    sa  = sext(ua, w);
    sb  = sext(ub, w);
    acc = ((u64_t'(h) & m1) << w) | (u64_t'(l) & m1);
    we  = 1'b1;
    r   = acc;
    case (o)
      MULT:  r = u64_t'(sa * sb);
      MULTU: r = ua * ub;
      MADD:  r = acc + u64_t'(sa * sb);
      MADDU: r = acc + ua * ub;
      MSUB:  r = acc - u64_t'(sa * sb);
      MSUBU: r = acc - ua * ub;
      DIV:   if (sb == 0) we = 1'b0;
             else r = ((u64_t'(sa % sb) & m1) << w) | (u64_t'(sa / sb) & m1);
      DIVU:  if (ub == 0) we = 1'b0;
             else r = ((ua % ub) << w) | (ua / ub);
      MTHI:  r = (ua << w) | (u64_t'(l) & m1);
      MTLO:  r = ((u64_t'(h) & m1) << w) | ua;
      default: we = 1'b0;
    endcase
    r = r & m2;
    return {we, 32'(r >> w), 32'(r & m1)};
  endfunction

  function automatic bit is_issue(input logic [3:0] o);
    return o inside {MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU};
  endfunction

  task automatic drive(input bit sel, input logic [3:0] o, input logic [31:0] a, b, input logic c);
    if (sel) begin
      m16.op = o; m16.rs_val = a[15:0]; m16.rt_val = b[15:0]; m16.cancel = c;
    end else begin
      m32.op = o; m32.rs_val = a; m32.rt_val = b; m32.cancel = c;
    end
  endtask

  task automatic peek(input bit sel, output logic bz, output logic [31:0] o, h, l);
    if (sel) begin
      bz = m16.busy; o = {16'd0, m16.out}; h = {16'd0, m16.hi}; l = {16'd0, m16.lo};
    end else begin
      bz = m32.busy; o = m32.out; h = m32.hi; l = m32.lo;
    end
  endtask

  // Apply one op for one cycle, then idle (cancel=cl) until busy drops.
  task automatic do_op(input bit sel, input logic [3:0] o, input logic [31:0] a, b,
                       input logic c, cl, output logic busy0, output logic [31:0] out0,
                       output int ncyc);
    logic bz;
    logic [31:0] x, h, l;
    drive(sel, o, a, b, c);
    #1;
    peek(sel, busy0, out0, h, l);
    @(posedge clk); #1;
    drive(sel, NONE, $urandom, $urandom, cl);
    #1;
    ncyc = 0;
    peek(sel, bz, x, h, l);
    while (bz && ncyc < 200) begin
      ncyc++;
      @(posedge clk); #2;
      peek(sel, bz, x, h, l);
    end
    chk("busy_timeout", 64'(bz), 64'(0));
    drive(sel, NONE, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic check_state(input bit sel, input string tag, input logic [31:0] eh, el);
    logic bz;
    logic [31:0] o, h, l;
    peek(sel, bz, o, h, l);
    chk({tag, "_busy"}, 64'(bz), 64'(0));
    chk({tag, "_hi"}, 64'(h), 64'(eh));
    chk({tag, "_lo"}, 64'(l), 64'(el));
  endtask

  task automatic run_checked(input bit sel, input logic [3:0] o, input logic [31:0] a, b,
                             input logic c, cl);
    int w, lat, ncyc;
    logic [64:0] r;
    logic [31:0] eo, out0;
    logic busy0;
    bit iss;
    w   = sel ? 16 : 32;
    iss = is_issue(o) && !c;
    lat = !iss ? 0 : (o inside {DIV, DIVU}) ? (sel ? 3 : 10) : (sel ? 1 : 5);
    eo  = (o == MFHI) ? mh[sel] : (o == MFLO) ? ml[sel] : 32'd0;
    r   = c ? 65'd0 : model(w, o, a, b, mh[sel], ml[sel]);
    if (r[64]) begin
      mh[sel] = r[63:32];
      ml[sel] = r[31:0];
    end
    do_op(sel, o, a, b, c, cl, busy0, out0, ncyc);
    chk("rnd_busy0", 64'(busy0), 64'(iss));
    chk("rnd_cycles", 64'(ncyc), 64'(lat));
    chk("rnd_out", 64'(out0), 64'(eo));
    check_state(sel, "rnd", mh[sel], ml[sel]);
  endtask

  // Issue, then assert reset so it is sampled at the second edge after issue.
  task automatic reset_mid(input bit sel, input logic [3:0] o, input logic [31:0] a, b);
    drive(sel, o, a, b, 1'b0);
    @(posedge clk); #1;
    drive(sel, NONE, 32'd0, 32'd0, 1'b0);
    @(posedge clk); #1;
    if (sel) rst16 = 1'b1; else rst32 = 1'b1;
    @(posedge clk); #1;
    if (sel) rst16 = 1'b0; else rst32 = 1'b0;
    #1;
    check_state(sel, "rstmid", 32'd0, 32'd0);
    repeat (12) @(posedge clk);
    #1;
    check_state(sel, "rstmid_late", 32'd0, 32'd0);
    mh[sel] = 32'd0;
    ml[sel] = 32'd0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic busy0;
    logic [31:0] out0;
    int ncyc;
    logic bz;
    logic [31:0] o, h, l;

    //            sel op     rs            rt            c  cl out           hi            lo            cyc
    tbl.push_back('{0, MULT,  32'hFFFFFFFE, 32'd3,        0, 0, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFA, 5});
    tbl.push_back('{0, MFLO,  32'd0,        32'd0,        0, 0, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFFA, 0});
    tbl.push_back('{0, DIV,   32'hFFFFFFF9, 32'd2,        0, 0, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFD, 10});
    tbl.push_back('{0, MFLO,  32'd0,        32'd0,        0, 0, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFD, 0});
    tbl.push_back('{0, MFHI,  32'd0,        32'd0,        0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFD, 0});
    tbl.push_back('{0, MTHI,  32'd5,        32'd0,        0, 0, 32'h0,        32'h5,        32'hFFFFFFFD, 0});
    tbl.push_back('{0, MTLO,  32'd1,        32'd0,        0, 0, 32'h0,        32'h5,        32'h1,        0});
    tbl.push_back('{0, MADDU, 32'd2,        32'd3,        0, 0, 32'h0,        32'h5,        32'h7,        5});
    tbl.push_back('{0, MSUBU, 32'd0,        32'd1,        0, 0, 32'h0,        32'h5,        32'h7,        5});
    tbl.push_back('{0, MTHI,  32'h11,       32'd0,        0, 0, 32'h0,        32'h11,       32'h7,        0});
    tbl.push_back('{0, MTLO,  32'h22,       32'd0,        0, 0, 32'h0,        32'h11,       32'h22,       0});
    tbl.push_back('{0, DIVU,  32'd5,        32'd0,        0, 0, 32'h0,        32'h11,       32'h22,       10});
    tbl.push_back('{0, MULT,  32'd7,        32'd7,        1, 0, 32'h0,        32'h11,       32'h22,       0});
    tbl.push_back('{0, MTHI,  32'h99,       32'd0,        1, 0, 32'h0,        32'h11,       32'h22,       0});
    tbl.push_back('{0, DIV,   32'h80000000, 32'hFFFFFFFF, 0, 0, 32'h0,        32'h0,        32'h80000000, 10});
    tbl.push_back('{0, MSUB,  32'd2,        32'd3,        0, 0, 32'h0,        32'h0,        32'h7FFFFFFA, 5});
    tbl.push_back('{0, MADD,  32'hFFFFFFFF, 32'd1,        0, 0, 32'h0,        32'h0,        32'h7FFFFFF9, 5});
    tbl.push_back('{0, MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 32'h0,        32'hFFFFFFFE, 32'h1,        5});
    tbl.push_back('{0, 4'd13, 32'd3,        32'd3,        0, 0, 32'h0,        32'hFFFFFFFE, 32'h1,        0});
    tbl.push_back('{0, MULT,  32'd4,        32'd5,        0, 1, 32'h0,        32'h0,        32'h14,       5});
    tbl.push_back('{0, MFHI,  32'd0,        32'd0,        0, 0, 32'h0,        32'h0,        32'h14,       0});
    tbl.push_back('{0, DIVU,  32'd100,      32'd7,        0, 0, 32'h0,        32'h2,        32'hE,        10});
    tbl.push_back('{0, DIV,   32'd7,        32'hFFFFFFFE, 0, 0, 32'h0,        32'h1,        32'hFFFFFFFD, 10});
    tbl.push_back('{1, MULT,  32'hFFFE,     32'd3,        0, 0, 32'h0,        32'hFFFF,     32'hFFFA,     1});
    tbl.push_back('{1, MFLO,  32'd0,        32'd0,        0, 0, 32'hFFFA,     32'hFFFF,     32'hFFFA,     0});
    tbl.push_back('{1, DIVU,  32'h64,       32'd7,        0, 0, 32'h0,        32'h2,        32'hE,        3});
    tbl.push_back('{1, DIV,   32'h8000,     32'hFFFF,     0, 0, 32'h0,        32'h0,        32'h8000,     3});
    tbl.push_back('{1, MADDU, 32'hFFFF,     32'hFFFF,     0, 0, 32'h0,        32'hFFFE,     32'h8001,     1});
    tbl.push_back('{1, DIV,   32'hFFF9,     32'd2,        0, 0, 32'h0,        32'hFFFF,     32'hFFFD,     3});

    drive(0, NONE, 32'd0, 32'd0, 1'b0);
    drive(1, NONE, 32'd0, 32'd0, 1'b0);
    rst32 = 1'b1;
    rst16 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst32 = 1'b0;
    rst16 = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) begin
      peek(s[0], bz, o, h, l);
      chk("reset_busy", 64'(bz), 64'(0));
      chk("reset_out", 64'(o), 64'(0));
      chk("reset_hi", 64'(h), 64'(0));
      chk("reset_lo", 64'(l), 64'(0));
    end

    foreach (tbl[i]) begin
      do_op(tbl[i].sel, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].cl, busy0, out0, ncyc);
      chk($sformatf("vec%0d_busy0", i), 64'(busy0), 64'(tbl[i].cyc != 0));
      chk($sformatf("vec%0d_cycles", i), 64'(ncyc), 64'(tbl[i].cyc));
      chk($sformatf("vec%0d_out", i), 64'(out0), 64'(tbl[i].eout));
      check_state(tbl[i].sel, $sformatf("vec%0d", i), tbl[i].ehi, tbl[i].elo);
      mh[tbl[i].sel] = tbl[i].ehi;
      ml[tbl[i].sel] = tbl[i].elo;
    end

    reset_mid(0, MULT, 32'd3, 32'd3);
    reset_mid(1, DIV, 32'd9, 32'd2);

    for (int s = 0; s < 2; s++) begin
      for (int n = 0; n < (s == 0 ? 150 : 80); n++) begin
        logic [3:0] ro;
        logic [31:0] ra, rb;
        logic rc, rcl;
        ro  = 4'($urandom_range(0, 15));
        rc  = ($urandom_range(0, 5) == 0);
        rcl = 1'($urandom_range(0, 1));
        ra  = $urandom;
        case ($urandom_range(0, 3))
          0: rb = 32'd0;
          1: rb = $urandom_range(1, 5);
          2: rb = 32'hFFFFFFFF;
          default: rb = $urandom;
        endcase
        if ($urandom_range(0, 7) == 0) ra = s ? 32'h8000 : 32'h80000000;
        run_checked(s[0], ro, ra, rb, rc, rcl);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/e_mdu_param.md
Name: e_mdu_param

Overview:
- Parametrised multiply/divide unit with HI/LO registers for the E stage of the 5-stage pipeline.
- Generalises the existing fixed-latency HILO unit in four ways:
  - configurable data width;
  - separately configurable multiply and divide latencies;
  - multiply-accumulate and multiply-subtract ops;
  - a cancel input, so an instruction being flushed (exception/interrupt) never issues.
- busy feeds the stall controller; out feeds the E→M register.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- MUL_CYCLES, 5, busy cycles for the mult/madd/msub class; must be ≥1.
- DIV_CYCLES, 10, busy cycles for the div class; must be ≥1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- op  in  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO, 9 MADD, 10 MADDU, 11 MSUB, 12 MSUBU; 13-15 behave as NONE.
- cancel  in  1  E-stage instruction is being flushed this cycle.
- rs_val  in  WIDTH  forwarded rs operand.
- rt_val  in  WIDTH  forwarded rt operand.
- busy  out  1  operation pending or issuing.
- out  out  WIDTH  MFHI→HI, MFLO→LO, otherwise 0.
- hi  out  WIDTH  committed HI, exposed for debug.
- lo  out  WIDTH  committed LO, exposed for debug.

Behaviour:
- Reset: HI=0, LO=0, cnt=0, pending results=0; busy=0 and out=0 in the cycle after reset.
  - Reset asserted mid-operation aborts it; nothing is committed.
- Definitions:
  - issue = op in {1,2,3,4,9..12} & !cancel & (cnt==0).
  - busy = (cnt!=0) | issue (combinational; the stall controller uses it directly).
- Issue, at the edge where issue=1:
  - Compute the result from rs_val/rt_val and store it in pending hi/lo.
  - Load cnt with MUL_CYCLES (classes 1,2,9-12) or DIV_CYCLES (classes 3,4).
- Countdown:
  - Each edge with cnt!=0 decrements cnt.
  - On the edge where cnt goes 1→0, pending values commit to HI/LO.
  - A multiply issued at edge k commits at edge k+MUL_CYCLES; busy is high from issue through the cycle before the commit edge.
- Arithmetic:
  - MULT/MULTU: {HI,LO} = signed/unsigned 2·WIDTH-bit product.
  - MADD(U): {HI,LO} = {HI,LO} + product. MSUB(U): {HI,LO} = {HI,LO} − product. Both wrap modulo 2^(2·WIDTH).
  - The {HI,LO} used for MADD/MSUB is the value committed at issue time.
- Division:
  - DIV: LO = quotient truncated toward zero, HI = remainder with the dividend's sign.
  - DIVU is the unsigned equivalent.
  - Divisor 0: the op still occupies DIV_CYCLES busy cycles, but HI/LO are left unchanged at commit.
  - Signed overflow (most-negative / −1): LO = most-negative, HI = 0.
- MTHI/MTLO: write rs_val into HI/LO at the edge, only when !cancel & cnt==0; otherwise dropped.
- MFHI/MFLO: out is combinational from committed HI/LO. A value read while busy=1 is stale; the controller must stall.
- cancel:
  - Suppresses issue and MT writes in the same cycle.
  - Does not affect an operation already in flight.
- Ops arriving while cnt!=0 (any class) are ignored. The pipeline guarantees this cannot happen; a verification assertion flags it.

Test Plan:
- Reset, then MULT rs=0xFFFFFFFE rt=3 at edge 0 → busy high for 5 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFA after edge 5; busy=0 in the cycle after edge 5.
- DIV rs=-7 rt=2, then MFLO/MFHI after completion → out=0xFFFFFFFD (−3), then 0xFFFFFFFF (−1); busy spans 10 cycles.
- MTHI 5, MTLO 1, then MADDU rs=2 rt=3 → {HI,LO}=0x00000005_00000007. MSUBU rs=0 rt=1 leaves the result unchanged.
- DIVU rt=0 with HI=0x11, LO=0x22 → busy for 10 cycles; HI/LO still 0x11/0x22 afterwards.
- MULT with cancel=1 → no busy, HI/LO unchanged. MULT issued, then cancel=1 during countdown → result still commits at edge +5.
- MULT issued, reset asserted at edge 2 → HI=LO=0, busy=0, no later commit. Repeat with parameters WIDTH=16, MUL_CYCLES=1 → 16-bit results commit at edge +1.
